// File: rtl/ysyx_22040750_csr_pkg.sv
// Shared constants for the ysyx_22040750 machine-mode CSR file:
// CSR addresses, op encodings, interrupt cause codes, mstatus/mip bit
// positions and mstatus reset images.
package ysyx_22040750_csr_pkg;

  // Machine-mode CSR addresses
  localparam logic [11:0] CSR_MSTATUS   = 12'h300;
  localparam logic [11:0] CSR_MIE       = 12'h304;
  localparam logic [11:0] CSR_MTVEC     = 12'h305;
  localparam logic [11:0] CSR_MSCRATCH  = 12'h340;
  localparam logic [11:0] CSR_MEPC      = 12'h341;
  localparam logic [11:0] CSR_MCAUSE    = 12'h342;
  localparam logic [11:0] CSR_MIP       = 12'h344;

  // Hardware counters and their user-mode read-only aliases
  localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
  localparam logic [11:0] CSR_MINSTRET  = 12'hB02;
  localparam logic [11:0] CSR_MCYCLEH   = 12'hB80;
  localparam logic [11:0] CSR_MINSTRETH = 12'hB82;
  localparam logic [11:0] CSR_CYCLE     = 12'hC00;
  localparam logic [11:0] CSR_INSTRET   = 12'hC02;

  typedef enum logic [1:0] {
    CSR_OP_NONE  = 2'b00,
    CSR_OP_WRITE = 2'b01,
    CSR_OP_SET   = 2'b10,
    CSR_OP_CLEAR = 2'b11
  } csr_op_e;

  // Interrupt cause codes (mcause low bits)
  localparam int CAUSE_MTI = 7;
  localparam int CAUSE_MSI = 3;

  // Bit positions inside mstatus and mip/mie
  localparam int MSTATUS_MIE  = 3;
  localparam int MSTATUS_MPIE = 7;
  localparam int MIP_MTIP     = 7;
  localparam int MIP_MSIP     = 3;

  // mstatus reset images: MPP=2'b11, and for RV64 also SXL/UXL=2
  localparam logic [63:0] MSTATUS_RST_64 = 64'h0000_000A_0000_1800;
  localparam logic [63:0] MSTATUS_RST_32 = 64'h0000_0000_0000_1800;

  // Read-modify-write result of a CSR instruction
  function automatic logic [63:0] csr_apply_op(input csr_op_e op,
                                               input logic [63:0] old_v,
                                               input logic [63:0] d);
    case (op)
      CSR_OP_WRITE: return d;
      CSR_OP_SET:   return old_v | d;
      CSR_OP_CLEAR: return old_v & ~d;
      default:      return old_v;
    endcase
  endfunction

endpackage

// File: rtl/ysyx_22040750_csr_counter.sv
// 64-bit event counter (mcycle / minstret). A software write wins over the
// increment in the same cycle; with XLEN=32 the halves are written separately.
module ysyx_22040750_csr_counter #(
  parameter int XLEN = 64
) (
  input  logic            I_sys_clk,
  input  logic            I_rst_n,
  input  logic            I_inc,
  input  logic            I_wr_lo,
  input  logic            I_wr_hi,
  input  logic [XLEN-1:0] I_wr_data,
  output logic [63:0]     O_count
);

  logic [63:0] cnt;

  // Counter register: write overrides increment, synchronous reset to zero
  always_ff @(posedge I_sys_clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values; blocking here would create order-dependent races.
    if (!I_rst_n) begin
      cnt <= 64'd0;
    end else if (I_wr_lo || I_wr_hi) begin
      if (I_wr_lo) begin
        if (XLEN == 64) cnt <= 64'(I_wr_data);
        else            cnt[31:0] <= I_wr_data[31:0];
      end
      if (I_wr_hi) cnt[63:32] <= I_wr_data[31:0];
    end else if (I_inc) begin
      cnt <= cnt + 64'd1;
    end
  end

  assign O_count = cnt;

endmodule

// File: rtl/ysyx_22040750_csr_file.sv
// Machine-mode CSR file at the MEM/WB boundary: combinational reads,
// set/clear/write ops, trap entry (exception > interrupt), mret, and a
// registered one-cycle redirect pulse.
// Optional feature macro: YSYX_22040750_CSR_COUNTERS_EN adds mcycle/minstret
// (plus mcycleh/minstreth for XLEN=32) and read-only cycle/instret aliases.
module ysyx_22040750_csr_file
  import ysyx_22040750_csr_pkg::*;
#(
  parameter int XLEN = 64,
  parameter int PC_W = 32
) (
  input  logic            I_sys_clk,
  input  logic            I_rst_n,
  input  logic            I_MEM_WB_valid,
  input  logic            I_csr_wen,
  input  logic [1:0]      I_csr_op,
  input  logic [11:0]     I_wr_addr,
  input  logic [11:0]     I_rd_addr,
  input  logic [XLEN-1:0] I_wr_data,
  input  logic            I_exc,
  input  logic [XLEN-1:0] I_exc_cause,
  input  logic [PC_W-1:0] I_pc,
  input  logic [PC_W-1:0] I_next_pc,
  input  logic            I_mret,
  input  logic            I_mtip,
  input  logic            I_msip,
  output logic [XLEN-1:0] O_rd_data,
  output logic            O_illegal,
  output logic            O_intr_pend,
  output logic            O_redirect_valid,
  output logic [PC_W-1:0] O_redirect_pc
);

  localparam logic [XLEN-1:0] MSTATUS_FIXED =
    (XLEN == 64) ? XLEN'(MSTATUS_RST_64) : XLEN'(MSTATUS_RST_32);

  // Architectural state; mstatus only holds its two writable bits
  logic            st_mie, st_mpie;
  logic [XLEN-1:0] mie_q, mtvec_q, mscratch_q, mepc_q, mcause_q;
  logic            mtip_q, msip_q;
  logic            redirect_valid_q;
  logic [PC_W-1:0] redirect_pc_q;

`ifdef YSYX_22040750_CSR_COUNTERS_EN
  logic [63:0] mcycle, minstret;
`endif

  logic [XLEN-1:0] mstatus_rd, mip_rd;
  logic [XLEN-1:0] csr_old, csr_new;
  logic            csr_wr_act;
  logic            mti_pend, msi_pend, intr_take;
  logic [XLEN-1:0] intr_mcause, mtvec_base, intr_target;

  // Write-accessible addresses (read-only aliases excluded)
  function automatic logic csr_writable(input logic [11:0] addr);
    case (addr)
      CSR_MSTATUS, CSR_MIE, CSR_MTVEC, CSR_MSCRATCH,
      CSR_MEPC, CSR_MCAUSE, CSR_MIP:    return 1'b1;
`ifdef YSYX_22040750_CSR_COUNTERS_EN
      CSR_MCYCLE, CSR_MINSTRET:         return 1'b1;
      CSR_MCYCLEH, CSR_MINSTRETH:       return (XLEN == 32);
`endif
      default:                          return 1'b0;
    endcase
  endfunction

  // Read mux over current state; unimplemented addresses read zero
  function automatic logic [XLEN-1:0] csr_read(input logic [11:0] addr);
    case (addr)
      CSR_MSTATUS:  return mstatus_rd;
      CSR_MIE:      return mie_q;
      CSR_MTVEC:    return mtvec_q;
      CSR_MSCRATCH: return mscratch_q;
      CSR_MEPC:     return mepc_q;
      CSR_MCAUSE:   return mcause_q;
      CSR_MIP:      return mip_rd;
`ifdef YSYX_22040750_CSR_COUNTERS_EN
      CSR_MCYCLE, CSR_CYCLE:     return XLEN'(mcycle);
      CSR_MINSTRET, CSR_INSTRET: return XLEN'(minstret);
      CSR_MCYCLEH:   return (XLEN == 32) ? XLEN'(mcycle[63:32])   : '0;
      CSR_MINSTRETH: return (XLEN == 32) ? XLEN'(minstret[63:32]) : '0;
`endif
      default:      return '0;
    endcase
  endfunction

  // Assemble mstatus/mip read images and the read ports
  always_comb begin
    // NOTE: every always_comb output gets a full default first so no path
    // leaves it unassigned, which would otherwise infer a latch.
    mstatus_rd               = MSTATUS_FIXED;
    mstatus_rd[MSTATUS_MIE]  = st_mie;
    mstatus_rd[MSTATUS_MPIE] = st_mpie;
    mip_rd                   = '0;
    mip_rd[MIP_MTIP]         = mtip_q;
    mip_rd[MIP_MSIP]         = msip_q;
    O_rd_data                = csr_read(I_rd_addr);
    csr_old                  = csr_read(I_wr_addr);
    csr_new = XLEN'(csr_apply_op(csr_op_e'(I_csr_op), 64'(csr_old), 64'(I_wr_data)));
  end

  // CSR instruction takes effect unless it faults or is displaced by mret
  assign csr_wr_act = I_MEM_WB_valid & I_csr_wen & (I_csr_op != CSR_OP_NONE) &
                      ~I_exc & ~I_mret & csr_writable(I_wr_addr);
  assign O_illegal  = I_csr_wen & ~csr_writable(I_wr_addr);

  // Interrupt arbitration and trap vector computation
  always_comb begin
    mti_pend    = mie_q[MIP_MTIP] & mtip_q;
    msi_pend    = mie_q[MIP_MSIP] & msip_q;
    O_intr_pend = st_mie & (mti_pend | msi_pend);
    intr_take   = I_MEM_WB_valid & O_intr_pend & ~I_exc;
    intr_mcause = mti_pend ? XLEN'(CAUSE_MTI) : XLEN'(CAUSE_MSI);
    intr_mcause[XLEN-1] = 1'b1;
    mtvec_base  = {mtvec_q[XLEN-1:2], 2'b00};
    intr_target = mtvec_base;
    if (mtvec_q[0])
      intr_target = mtvec_base + (mti_pend ? XLEN'(CAUSE_MTI * 4) : XLEN'(CAUSE_MSI * 4));
  end

  // CSR state, trap entry/exit and the registered redirect
  always_ff @(posedge I_sys_clk) begin
    if (!I_rst_n) begin
      st_mie           <= 1'b0;
      st_mpie          <= 1'b0;
      mie_q            <= '0;
      mtvec_q          <= '0;
      mscratch_q       <= '0;
      mepc_q           <= '0;
      mcause_q         <= '0;
      mtip_q           <= 1'b0;
      msip_q           <= 1'b0;
      redirect_valid_q <= 1'b0;
      redirect_pc_q    <= '0;
    end else begin
      mtip_q           <= I_mtip;
      msip_q           <= I_msip;
      redirect_valid_q <= 1'b0;
      if (I_MEM_WB_valid && I_exc) begin
        mepc_q           <= XLEN'(I_pc);
        mcause_q         <= I_exc_cause;
        st_mpie          <= st_mie;
        st_mie           <= 1'b0;
        redirect_valid_q <= 1'b1;
        redirect_pc_q    <= PC_W'(mtvec_base);
      end else begin
        if (csr_wr_act) begin
          case (I_wr_addr)
            CSR_MSTATUS: begin
              st_mie  <= csr_new[MSTATUS_MIE];
              st_mpie <= csr_new[MSTATUS_MPIE];
            end
            CSR_MIE:      mie_q      <= csr_new;
            CSR_MTVEC:    mtvec_q    <= csr_new & ~XLEN'(2);
            CSR_MSCRATCH: mscratch_q <= csr_new;
            CSR_MEPC:     mepc_q     <= csr_new;
            CSR_MCAUSE:   mcause_q   <= csr_new;
            default: ;
          endcase
        end
        // Trap fields below override a same-cycle CSR write to them
        if (intr_take) begin
          mepc_q           <= XLEN'(I_next_pc);
          mcause_q         <= intr_mcause;
          st_mpie          <= st_mie;
          st_mie           <= 1'b0;
          redirect_valid_q <= 1'b1;
          redirect_pc_q    <= PC_W'(intr_target);
        end else if (I_MEM_WB_valid && I_mret) begin
          st_mie           <= st_mpie;
          st_mpie          <= 1'b1;
          redirect_valid_q <= 1'b1;
          redirect_pc_q    <= PC_W'(mepc_q);
        end
      end
    end
  end

  assign O_redirect_valid = redirect_valid_q;
  assign O_redirect_pc    = redirect_pc_q;

`ifdef YSYX_22040750_CSR_COUNTERS_EN
  logic mcycle_wr_lo, mcycle_wr_hi, minstret_wr_lo, minstret_wr_hi, minstret_inc;

  // Counter write strobes and retire event
  always_comb begin
    mcycle_wr_lo   = csr_wr_act & (I_wr_addr == CSR_MCYCLE);
    minstret_wr_lo = csr_wr_act & (I_wr_addr == CSR_MINSTRET);
    mcycle_wr_hi   = csr_wr_act & (XLEN == 32) & (I_wr_addr == CSR_MCYCLEH);
    minstret_wr_hi = csr_wr_act & (XLEN == 32) & (I_wr_addr == CSR_MINSTRETH);
    minstret_inc   = I_MEM_WB_valid & ~I_exc;
  end

  ysyx_22040750_csr_counter #(.XLEN(XLEN)) u_mcycle (
    .I_sys_clk (I_sys_clk),
    .I_rst_n   (I_rst_n),
    .I_inc     (1'b1),
    .I_wr_lo   (mcycle_wr_lo),
    .I_wr_hi   (mcycle_wr_hi),
    .I_wr_data (csr_new),
    .O_count   (mcycle)
  );

  ysyx_22040750_csr_counter #(.XLEN(XLEN)) u_minstret (
    .I_sys_clk (I_sys_clk),
    .I_rst_n   (I_rst_n),
    .I_inc     (minstret_inc),
    .I_wr_lo   (minstret_wr_lo),
    .I_wr_hi   (minstret_wr_hi),
    .I_wr_data (csr_new),
    .O_count   (minstret)
  );
`endif

endmodule

// File: tb/tb_ysyx_22040750_csr_file.sv
// Scoreboard bench for ysyx_22040750_csr_file (XLEN=64, PC_W=32): a driver
// issues stimulus and pushes expectations from a behavioural model; a monitor
// on the falling edge pops and compares them.
module tb_ysyx_22040750_csr_file;

  localparam int XLEN = 64;
  localparam int PC_W = 32;

  logic            clk, rst_n, valid, wen, exc, mret, mtip, msip;
  logic [1:0]      op;
  logic [11:0]     wa, ra;
  logic [63:0]     wd, cause;
  logic [31:0]     pc, npc;
  logic [63:0]     rd_data;
  logic            illegal, intr_pend, redir_v;
  logic [31:0]     redir_pc;

  ysyx_22040750_csr_file #(.XLEN(XLEN), .PC_W(PC_W)) dut (
    .I_sys_clk        (clk),
    .I_rst_n          (rst_n),
    .I_MEM_WB_valid   (valid),
    .I_csr_wen        (wen),
    .I_csr_op         (op),
    .I_wr_addr        (wa),
    .I_rd_addr        (ra),
    .I_wr_data        (wd),
    .I_exc            (exc),
    .I_exc_cause      (cause),
    .I_pc             (pc),
    .I_next_pc        (npc),
    .I_mret           (mret),
    .I_mtip           (mtip),
    .I_msip           (msip),
    .O_rd_data        (rd_data),
    .O_illegal        (illegal),
    .O_intr_pend      (intr_pend),
    .O_redirect_valid (redir_v),
    .O_redirect_pc    (redir_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  typedef struct {
    bit        rst_n, chk, valid, wen, exc, mret, mtip, msip;
    bit [1:0]  op;
    bit [11:0] wa, ra;
    bit [63:0] wd, cause;
    bit [31:0] pc, npc;
  } stim_t;

  typedef struct { int cyc; bit [63:0] rd; bit ill; bit pend; } comb_exp_t;
  typedef struct { int cyc; bit v; bit [31:0] pc; } redir_exp_t;

  comb_exp_t  comb_q[$];
  redir_exp_t redir_q[$];
  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s cycle=%0d got=%h want=%h", name, cyc, got, want);
    end
  endtask

  // ---------------- behavioural model ----------------
  bit [63:0] m_mstatus, m_mie, m_mtvec, m_mscratch, m_mepc, m_mcause, m_mip;
  bit [63:0] m_mcycle, m_minstret;

  task automatic m_reset();
    m_mstatus = 64'hA_0000_1800;
    m_mie = 0; m_mtvec = 0; m_mscratch = 0; m_mepc = 0; m_mcause = 0; m_mip = 0;
    m_mcycle = 0; m_minstret = 0;
  endtask

  function automatic bit m_writable(bit [11:0] a);
    case (a)
      12'h300, 12'h304, 12'h305, 12'h340, 12'h341, 12'h342, 12'h344: return 1'b1;
`ifdef YSYX_22040750_CSR_COUNTERS_EN
      12'hB00, 12'hB02: return 1'b1;
`endif
      default: return 1'b0;
    endcase
  endfunction

  function automatic bit [63:0] m_read(bit [11:0] a);
    case (a)
      12'h300: return m_mstatus;
      12'h304: return m_mie;
      12'h305: return m_mtvec;
      12'h340: return m_mscratch;
      12'h341: return m_mepc;
      12'h342: return m_mcause;
      12'h344: return m_mip;
`ifdef YSYX_22040750_CSR_COUNTERS_EN
      12'hB00, 12'hC00: return m_mcycle;
      12'hB02, 12'hC02: return m_minstret;
`endif
      default: return 64'd0;
    endcase
  endfunction

  function automatic bit m_pend();
    return m_mstatus[3] && ((m_mie & m_mip & 64'h88) != 0);
  endfunction

  // Advance the model across one clock edge; report the redirect it causes
  task automatic m_step(input stim_t s, output bit rv, output bit [31:0] rpc);
    bit [63:0] o_mstatus, o_mtvec, o_mepc, nv, old;
    bit        pend, mti, do_wr;
    int        code;
    rv = 0; rpc = 0;
    if (!s.rst_n) begin m_reset(); return; end
    o_mstatus = m_mstatus; o_mtvec = m_mtvec; o_mepc = m_mepc;
    pend = m_pend();
    mti  = m_mie[7] && m_mip[7];
    do_wr = s.valid && !s.exc && s.wen && s.op != 2'b00 && !s.mret && m_writable(s.wa);
    old = m_read(s.wa);
    nv  = (s.op == 2'b01) ? s.wd : (s.op == 2'b10) ? (old | s.wd) : (old & ~s.wd);
    m_mcycle++;
    if (s.valid) begin
      if (s.exc) begin
        m_mepc = {32'd0, s.pc};
        m_mcause = s.cause;
        m_mstatus[7] = o_mstatus[3];
        m_mstatus[3] = 1'b0;
        rv = 1; rpc = o_mtvec[31:0] & ~32'h3;
      end else begin
        m_minstret++;
        if (do_wr) begin
          case (s.wa)
            12'h300: m_mstatus = (m_mstatus & ~64'h88) | (nv & 64'h88);
            12'h304: m_mie = nv;
            12'h305: m_mtvec = nv & ~64'h2;
            12'h340: m_mscratch = nv;
            12'h341: m_mepc = nv;
            12'h342: m_mcause = nv;
            12'hB00: m_mcycle = nv;
            12'hB02: m_minstret = nv;
            default: ;
          endcase
        end
        if (pend) begin
          code = mti ? 7 : 3;
          m_mepc = {32'd0, s.npc};
          m_mcause = {1'b1, 63'(code)};
          m_mstatus[7] = o_mstatus[3];
          m_mstatus[3] = 1'b0;
          rv = 1;
          rpc = (o_mtvec[31:0] & ~32'h3) + (o_mtvec[0] ? 32'(4 * code) : 32'd0);
        end else if (s.mret) begin
          m_mstatus[3] = o_mstatus[7];
          m_mstatus[7] = 1'b1;
          rv = 1; rpc = o_mepc[31:0];
        end
      end
    end
    m_mip = ({63'd0, s.mtip} << 7) | ({63'd0, s.msip} << 3);
  endtask

  // ---------------- driver ----------------
  function automatic stim_t idle();
    stim_t s;
    s = '{rst_n: 1, chk: 1, valid: 0, wen: 0, exc: 0, mret: 0, mtip: 0, msip: 0,
          op: 0, wa: 0, ra: 0, wd: 0, cause: 0, pc: 0, npc: 0};
    return s;
  endfunction

  task automatic step(input stim_t s, input bit pin, input bit [63:0] pin_val);
    bit rv; bit [31:0] rpc;
    @(posedge clk); #1;
    rst_n = s.rst_n; valid = s.valid; wen = s.wen; op = s.op; wa = s.wa; ra = s.ra;
    wd = s.wd; exc = s.exc; cause = s.cause; pc = s.pc; npc = s.npc; mret = s.mret;
    mtip = s.mtip; msip = s.msip;
    if (s.chk)
      comb_q.push_back('{cyc, pin ? pin_val : m_read(s.ra), s.wen && !m_writable(s.wa), m_pend()});
    m_step(s, rv, rpc);
    redir_q.push_back('{cyc + 1, rv, rpc});
  endtask

  task automatic do_csr(input bit [1:0] o, input bit [11:0] a, input bit [63:0] d);
    stim_t s = idle();
    s.valid = 1; s.wen = 1; s.op = o; s.wa = a; s.ra = a; s.wd = d;
    step(s, 0, 0);
  endtask

  task automatic do_read(input bit [11:0] a, input bit [63:0] want);
    stim_t s = idle();
    s.ra = a;
    step(s, 1, want);
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin : monitor
    comb_exp_t  ce;
    redir_exp_t re;
    while (comb_q.size() > 0 && comb_q[0].cyc == cyc) begin
      ce = comb_q.pop_front();
      check("rd_data", rd_data, ce.rd);
      check("illegal", {63'd0, illegal}, {63'd0, ce.ill});
      check("intr_pend", {63'd0, intr_pend}, {63'd0, ce.pend});
    end
    while (redir_q.size() > 0 && redir_q[0].cyc == cyc) begin
      re = redir_q.pop_front();
      check("redirect_valid", {63'd0, redir_v}, {63'd0, re.v});
      if (re.v) check("redirect_pc", {32'd0, redir_pc}, {32'd0, re.pc});
    end
  end

  bit [11:0] addrs [14] = '{12'h300, 12'h304, 12'h305, 12'h340, 12'h341, 12'h342, 12'h344,
                           12'hB00, 12'hB02, 12'hC00, 12'hC02, 12'h301, 12'h7C0, 12'hF14};

  initial begin
    stim_t s;
    rst_n = 0; valid = 0; wen = 0; op = 0; wa = 0; ra = 0; wd = 0; exc = 0;
    cause = 0; pc = 0; npc = 0; mret = 0; mtip = 0; msip = 0;
    m_reset();

    // Reset: outputs undefined before the first reset edge, so not compared
    s = idle(); s.rst_n = 0; s.chk = 0;
    step(s, 0, 0);
    step(s, 0, 0);
    do_read(12'h300, 64'hA_0000_1800);
    do_read(12'h305, 64'd0);

    // mtvec write and mstatus set/clear
    do_csr(2'b01, 12'h305, 64'h8000_0101);
    do_read(12'h305, 64'h8000_0101);
    do_csr(2'b10, 12'h300, 64'h8);
    do_read(12'h300, 64'hA_0000_1808);
    do_csr(2'b11, 12'h300, 64'h1);
    do_read(12'h300, 64'hA_0000_1808);
    do_csr(2'b11, 12'h300, 64'h8);
    do_read(12'h300, 64'hA_0000_1800);
    do_csr(2'b01, 12'h344, 64'h88);
    do_read(12'h344, 64'd0);
    do_csr(2'b01, 12'h7C0, 64'h5);

    // ecall with MIE=1
    do_csr(2'b01, 12'h305, 64'h8000_0100);
    do_csr(2'b10, 12'h300, 64'h8);
    s = idle(); s.valid = 1; s.exc = 1; s.cause = 64'd11; s.pc = 32'h8000_0010; s.npc = 32'h8000_0014;
    step(s, 0, 0);
    do_read(12'h341, 64'h8000_0010);
    do_read(12'h342, 64'd11);
    do_read(12'h300, 64'hA_0000_1880);

    // Vectored timer interrupt
    do_csr(2'b01, 12'h305, 64'h8000_0101);
    do_csr(2'b01, 12'h304, 64'h80);
    do_csr(2'b10, 12'h300, 64'h8);
    s = idle(); s.mtip = 1;
    step(s, 0, 0);
    s = idle(); s.valid = 1; s.mtip = 1; s.pc = 32'h8000_0020; s.npc = 32'h8000_0024;
    step(s, 0, 0);
    do_read(12'h342, 64'h8000_0000_0000_0007);
    do_read(12'h341, 64'h8000_0024);

    // mret, then mret under reset
    do_csr(2'b01, 12'h341, 64'h8000_0014);
    s = idle(); s.valid = 1; s.mret = 1;
    step(s, 0, 0);
    do_read(12'h300, 64'hA_0000_1888);
    s = idle(); s.valid = 1; s.mret = 1; s.rst_n = 0;
    step(s, 0, 0);
    do_read(12'h300, 64'hA_0000_1800);
    do_read(12'h341, 64'd0);

`ifdef YSYX_22040750_CSR_COUNTERS_EN
    // Counters: reset, then 10 cycles with 4 valid retires, one faulting
    s = idle(); s.rst_n = 0;
    step(s, 0, 0);
    for (int k = 0; k < 10; k++) begin
      s = idle();
      s.valid = (k == 1 || k == 3 || k == 5 || k == 7);
      s.exc = (k == 5); s.cause = 64'd2;
      step(s, 0, 0);
    end
    do_read(12'hB00, 64'd10);
    do_read(12'hB02, 64'd3);
    do_csr(2'b01, 12'hC00, 64'd0);
    do_csr(2'b01, 12'hB02, 64'd100);
    do_read(12'hC02, 64'd100);
`endif

    // Randomized traffic
    for (int n = 0; n < 600; n++) begin
      int r;
      s = idle();
      r = $urandom_range(0, 9);
      s.ra = addrs[$urandom_range(0, 13)];
      s.mtip = ($urandom_range(0, 7) == 0);
      s.msip = ($urandom_range(0, 7) == 0);
      s.pc = $urandom & ~32'h3;
      s.npc = s.pc + 32'd4;
      if (r <= 1) begin
        s.wen = $urandom_range(0, 1); s.op = 2'($urandom_range(0, 3));
        s.wa = addrs[$urandom_range(0, 13)]; s.wd = {$urandom, $urandom};
      end else if (r <= 5) begin
        s.valid = ($urandom_range(0, 3) != 0); s.wen = 1; s.op = 2'($urandom_range(0, 3));
        s.wa = addrs[$urandom_range(0, 13)];
        s.wd = ($urandom_range(0, 1) != 0) ? {$urandom, $urandom} : 64'($urandom_range(0, 255));
      end else if (r == 6) begin
        s.valid = 1; s.exc = 1; s.cause = 64'($urandom_range(0, 15));
      end else if (r == 7) begin
        s.valid = 1; s.mret = 1;
      end else begin
        s.valid = 1;
      end
      if ($urandom_range(0, 149) == 0) s.rst_n = 0;
      step(s, 0, 0);
    end

    s = idle();
    step(s, 0, 0);
    @(posedge clk);
    @(negedge clk);
    @(negedge clk);
    check("scoreboard_drained", 64'(comb_q.size() + redir_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/ysyx_22040750_csr_file.md
# ysyx_22040750_csr_file

Parametrised machine-mode CSR file for the ysyx_22040750 in-order pipeline, written and read at the MEM/WB boundary. Adds CSR set/clear ops, mscratch, live mip from the CLINT, interrupt arbitration, vectored mtvec, a registered trap/mret redirect, and optional hardware cycle/retire counters. Reads are combinational; every state change is qualified by I_MEM_WB_valid.

## Interface
- XLEN, 64: CSR data width (32 or 64)
- PC_W, 32: PC width; mepc zero-extended to XLEN
- I_sys_clk  in  1  clock
- I_rst_n  in  1  reset: synchronous and active-low
- I_MEM_WB_valid  in  1  instruction in WB is valid / retiring
- I_csr_wen  in  1  CSR instruction in WB
- I_csr_op  in  2  01 write, 10 set, 11 clear, 00 none
- I_wr_addr, I_rd_addr  in  12  CSR addresses
- I_wr_data  in  XLEN  rs1/zimm operand
- I_exc  in  1  synchronous exception (ecall, etc.) in WB
- I_exc_cause  in  XLEN  cause code for I_exc
- I_pc, I_next_pc  in  PC_W  PC of WB instruction / its sequential successor
- I_mret  in  1  mret in WB
- I_mtip, I_msip  in  1  timer / software interrupt levels from CLINT
- O_rd_data  out  XLEN  combinational read of I_rd_addr
- O_illegal  out  1  I_csr_wen to unimplemented address
- O_intr_pend  out  1  enabled interrupt pending (mstatus.MIE & mie & mip)
- O_redirect_valid  out  1  registered pipeline flush/redirect
- O_redirect_pc  out  PC_W  registered redirect target

## Operation
- Implemented: mstatus 0x300, mie 0x304, mtvec 0x305, mscratch 0x340, mepc 0x341, mcause 0x342, mip 0x344 (counters under Configuration); other addresses read 0, O_illegal=1 when accessed with I_csr_wen.
- New value: write = d; set = old|d; clear = old&~d. mstatus writable bits MIE[3], MPIE[7] only; MPP[12:11] fixed 2'b11. mip: MTIP[7], MSIP[3] mirror I_mtip/I_msip each cycle, software writes ignored. mtvec[1] forced 0; mtvec[0] = mode.
- Per valid cycle, priority: I_exc > interrupt > I_mret > CSR write.
- Exception: mepc←I_pc, mcause←I_exc_cause, MPIE←MIE, MIE←0, redirect to mtvec base.
- Interrupt taken when O_intr_pend & I_MEM_WB_valid & !I_exc; MTIP (cause 7) beats MSIP (cause 3); mcause MSB=1; mepc←I_next_pc (WB instruction completes, CSR write still applied). Vectored mode: target = base + 4·cause.
- mret: MIE←MPIE, MPIE←1, redirect to mepc.
- Reset: mstatus = 0xA_0000_1800 (XLEN=64) / 0x1800 (XLEN=32); all other CSRs 0; O_redirect_valid=0, O_redirect_pc=0; O_illegal/O_intr_pend follow reset state (0).

## Timing
- O_rd_data combinational; read-during-write to same address returns old value (pipeline forwards).
- CSR/trap updates on the rising edge of the valid cycle.
- O_redirect_valid is a one-cycle pulse the cycle after trap/mret; O_redirect_pc stable with it.
- I_rst_n low mid-trap: redirect pulse suppressed, all state to reset values at that edge.
- Invalid cycle (I_MEM_WB_valid=0): no architectural update except mip mirror and mcycle.

## Configuration
- YSYX_22040750_CSR_COUNTERS_EN defined: 64-bit mcycle (0xB00) increments every cycle; minstret (0xB02) increments per valid cycle without I_exc; both writable (write overrides increment that cycle); XLEN=32 adds mcycleh 0xB80 / minstreth 0xB82 high halves; user aliases 0xC00/0xC02 read-only (write → O_illegal).
- Not defined: counter addresses unimplemented (read 0, O_illegal on write); no counter registers.

## Structure
- Package ysyx_22040750_csr_pkg: CSR address constants, cause codes (MTI=7, MSI=3), mstatus bit indices, op encodings, mstatus reset constants.
- Sub-module ysyx_22040750_csr_counter: 64-bit counter with inc, lo/hi write enables, parametrised by XLEN; instantiated twice.

## Test plan
- Reset then read 0x300 → 0xA00001800; 0x305 → 0; O_redirect_valid=0.
- csrw mtvec 0x80000101 then set 0x8 / clear 0x1 on mstatus → mtvec reads 0x80000101, mstatus toggles MIE, MPP stays 11.
- ecall at PC 0x80000010, cause 11, mtvec 0x80000100 → mepc=0x80000010, mcause=11, MIE→0/MPIE=old MIE, redirect 0x80000100 next cycle.
- MIE=1, mie[7]=1, I_mtip=1, vectored mtvec 0x80000101, I_next_pc 0x80000024 → mcause=0x8000000000000007, mepc=0x80000024, redirect 0x8000011C.
- mret with mepc 0x80000014, MPIE=1 → MIE=1, redirect 0x80000014; I_rst_n low on the redirect cycle → no pulse, state reset.
- COUNTERS_EN: 10 cycles, 4 valid retires with one I_exc → mcycle=10, minstret=3; write 0 to 0xC00 → O_illegal=1.
